bg_frame_sequencer: RTL
=======================

Name: bg_frame_sequencer

Overview:
- Frame-level controller for the OV7670 background-elimination stream.
- Tracks pixel position in the incoming camera stream and generates the AXI-Stream frame markers.
- Sequences the pipeline through sensor-settle, background-capture and run phases.
- Drives write addressing of the background frame memory during capture and read addressing during run.
- Sits between the camera capture interface and the background-compare datapath.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- SETTLE_FRAMES, 4, complete frames discarded after a capture request before the background is stored (auto-exposure settle).
- ADDR_W, 19, background memory address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- clk  in  1  pixel clock.
- resetn  in  1  asynchronous active-low reset.
- s_tvalid  in  1  camera pixel valid; no backpressure upstream.
- s_tdata  in  16  RGB565 pixel.
- frame_sync  in  1  single-cycle vsync pulse; resynchronises the position counters.
- capture_req  in  1  single-cycle request to (re)acquire the background.
- run_en  in  1  level; enables the RUN phase.
- m_tready  in  1  downstream ready.
- m_tvalid  out  1  output pixel valid.
- m_tdata  out  16  registered pixel.
- m_tuser  out  1  start of frame: first pixel, index 0.
- m_tlast  out  1  end of line: x == H_ACTIVE-1.
- bg_we  out  1  background memory write enable.
- bg_addr  out  ADDR_W  background write/read address (linear pixel index).
- state  out  2  0=IDLE, 1=SETTLE, 2=CAPTURE, 3=RUN.
- bg_valid  out  1  a complete background frame is stored.
- overflow  out  1  sticky: a pixel was dropped because m_tready was low.

Behaviour:
- Reset is asynchronous, active-low, on resetn; clock is clk.
- Reset values: all outputs 0, state IDLE, counters 0, capture request not pending.
- Position counters x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1) advance only on s_tvalid.
  - Linear index = y*H_ACTIVE + x, maintained incrementally, no multiplier.
  - End of frame (eof) = accepted pixel at x=H_ACTIVE-1, y=V_ACTIVE-1. Counters wrap to 0 on eof.
- frame_sync clears counters in the same cycle.
  - frame_sync together with s_tvalid: that pixel is index 0.
  - A frame cut short by frame_sync is aborted: no eof, and it does not count toward SETTLE.
- Latency: exactly 1 cycle from s_tvalid to m_tvalid, bg_we and bg_addr; m_tuser and m_tlast align with their pixel.
- m_tvalid = registered s_tvalid in every state; m_tdata is the registered pixel.
- Pixels presented while m_tready=0 are dropped, overflow is set, and counters still advance. Only resetn clears overflow.
- capture_req is latched as pending in any state; a repeat while pending has no effect.
- FSM (all transitions on eof only, except where stated):
  - IDLE: pending → SETTLE (clears pending and bg_valid); else run_en=1 and bg_valid=1 → RUN.
  - SETTLE: counts eofs; after SETTLE_FRAMES eofs → CAPTURE.
  - CAPTURE: bg_we = registered s_tvalid; bg_addr = index. On eof: bg_valid=1, then → RUN if run_en else IDLE.
    - An abort via frame_sync restarts capture at index 0, with bg_valid still 0.
  - RUN: bg_we=0; bg_addr = index, leading the pixel by 1 cycle for synchronous-read RAM alignment. At eof: pending → SETTLE; else run_en=0 → IDLE.
- capture_req arriving on the same cycle as eof: captured as pending and acted on at the next eof.
- resetn asserted mid-frame: everything returns to reset values; the next accepted pixel is index 0.

Optional Feature:
- Macro FRAME_STATS_EN.
- Defined:
  - adds output frame_cnt[15:0]: eofs in RUN, wrapping;
  - adds output drop_cnt[15:0]: dropped pixels, saturating at 0xFFFF;
  - both reset to 0.
- Undefined: neither port nor their counters exist; all other behaviour is identical.

Decomposition:
- Package bg_seq_pkg: state encoding constants, default H_ACTIVE/V_ACTIVE, FRAME_PIXELS = H_ACTIVE*V_ACTIVE, default ADDR_W.
- Sub-module frame_pos_counter: x, y, linear index, eol/eof flags, frame_sync resync. Instantiated once.

Test Plan:
- Test geometry for all scenarios: H_ACTIVE=8, V_ACTIVE=4, SETTLE_FRAMES=2.
- Scenario 1, reset and stream: stream continuous pixels → m_tuser on indices 0, 32, 64; m_tlast every 8th pixel; state stays IDLE; bg_we never asserted.
- Scenario 2, capture: capture_req mid-frame 0 → SETTLE at eof of frame 0, CAPTURE after 2 further eofs. Exactly 32 bg_we pulses with bg_addr 0..31; bg_valid=1 after the last pulse; run_en=1 → state 3.
- Scenario 3, abort: frame_sync at index 13 during CAPTURE → capture restarts at bg_addr 0; bg_valid stays 0 until 32 consecutive writes complete.
- Scenario 4, backpressure: m_tready=0 for pixels 5..7 → overflow=1 sticky; m_tlast still on index 7 of the stream count; drop_cnt=3 with FRAME_STATS_EN.
- Scenario 5, RUN exit: run_en deasserted at index 20 in RUN → state stays RUN through index 31, IDLE after eof.
- Scenario 6, reset mid-operation: resetn low at index 17 in CAPTURE → all outputs 0, state 0; next pixel indexed 0.

Source files
------------

// File: rtl/bg_seq_pkg.sv
// Shared constants for the background-elimination frame sequencer: state encoding and default
// frame geometry.
package bg_seq_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    localparam int unsigned H_ACTIVE_DEF      = 640;
    localparam int unsigned V_ACTIVE_DEF      = 480;
    localparam int unsigned FRAME_PIXELS      = H_ACTIVE_DEF * V_ACTIVE_DEF;
    localparam int unsigned ADDR_W_DEF        = 19;
    localparam int unsigned SETTLE_FRAMES_DEF = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// Pixel position tracker: x/y and linear index of the pixel on the input this cycle, with
// end-of-line / end-of-frame flags and frame_sync resynchronisation.
module frame_pos_counter
    import bg_seq_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_valid,
    input  logic              i_sync,
    output logic [ADDR_W-1:0] o_idx,
    output logic [ADDR_W-1:0] o_idx_nxt,
    output logic              o_eol,
    output logic              o_eof
);

    localparam int unsigned XW = cnt_w(H_ACTIVE);
    localparam int unsigned YW = cnt_w(V_ACTIVE);

    logic [XW-1:0]     r_x, w_x, w_x_nxt;
    logic [YW-1:0]     r_y, w_y, w_y_nxt;
    logic [ADDR_W-1:0] r_idx, w_idx, w_idx_nxt;

    // frame_sync overrides the stored position, so a pixel arriving with it is index 0.
    always_comb begin
        w_x   = i_sync ? '0 : r_x;
        w_y   = i_sync ? '0 : r_y;
        w_idx = i_sync ? '0 : r_idx;
        o_eol = i_valid && (w_x == XW'(H_ACTIVE - 1));
        o_eof = o_eol && (w_y == YW'(V_ACTIVE - 1));
        w_x_nxt   = w_x;
        w_y_nxt   = w_y;
        w_idx_nxt = w_idx;
        if (o_eof) begin
            w_x_nxt   = '0;
            w_y_nxt   = '0;
            w_idx_nxt = '0;
        end else if (o_eol) begin
            w_x_nxt   = '0;
            w_y_nxt   = w_y + YW'(1);
            w_idx_nxt = w_idx + ADDR_W'(1);
        end else if (i_valid) begin
            w_x_nxt   = w_x + XW'(1);
            w_idx_nxt = w_idx + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x   <= '0;
            r_y   <= '0;
            r_idx <= '0;
        end else begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_idx <= w_idx_nxt;
        end
    end

    assign o_idx     = w_idx;
    assign o_idx_nxt = w_idx_nxt;

endmodule

// File: rtl/bg_frame_sequencer.sv
// Frame-level controller for the OV7670 background-elimination stream: AXI-Stream markers,
// settle/capture/run sequencing and background memory addressing. FRAME_STATS_EN adds counters.
module bg_frame_sequencer
    import bg_seq_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE      = V_ACTIVE_DEF,
    parameter int unsigned SETTLE_FRAMES = SETTLE_FRAMES_DEF,
    parameter int unsigned ADDR_W        = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              s_tvalid,
    input  logic [15:0]       s_tdata,
    input  logic              frame_sync,
    input  logic              capture_req,
    input  logic              run_en,
    input  logic              m_tready,
    output logic              m_tvalid,
    output logic [15:0]       m_tdata,
    output logic              m_tuser,
    output logic              m_tlast,
    output logic              bg_we,
    output logic [ADDR_W-1:0] bg_addr,
    output logic [1:0]        state,
    output logic              bg_valid,
    output logic              overflow
`ifdef FRAME_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int unsigned SW = cnt_w(SETTLE_FRAMES);

    logic [ADDR_W-1:0] w_idx, w_idx_nxt;
    logic              w_eol, w_eof;

    logic [1:0]        r_state, w_state_nxt;
    logic [SW-1:0]     r_settle, w_settle_nxt;
    logic              r_pending, r_bg_valid, w_bg_valid_nxt, w_consume;
    logic              r_tvalid, r_tuser, r_tlast, r_bg_we, r_overflow;
    logic [15:0]       r_tdata;
    logic [ADDR_W-1:0] r_bg_addr;

    frame_pos_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .ADDR_W   (ADDR_W)
    ) u_pos (
        .clk       (clk),
        .resetn    (resetn),
        .i_valid   (s_tvalid),
        .i_sync    (frame_sync),
        .o_idx     (w_idx),
        .o_idx_nxt (w_idx_nxt),
        .o_eol     (w_eol),
        .o_eof     (w_eof)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_settle_nxt   = r_settle;
        w_bg_valid_nxt = r_bg_valid;
        w_consume      = 1'b0;
        if (w_eof) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pending) begin
                        w_state_nxt    = ST_SETTLE;
                        w_settle_nxt   = '0;
                        w_bg_valid_nxt = 1'b0;
                        w_consume      = 1'b1;
                    end else if (run_en && r_bg_valid) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == SW'(SETTLE_FRAMES - 1)) begin
                        w_state_nxt  = ST_CAPTURE;
                        w_settle_nxt = '0;
                    end else begin
                        w_settle_nxt = r_settle + SW'(1);
                    end
                end
                ST_CAPTURE: begin
                    w_bg_valid_nxt = 1'b1;
                    w_state_nxt    = run_en ? ST_RUN : ST_IDLE;
                end
                default: begin
                    if (r_pending) begin
                        w_state_nxt    = ST_SETTLE;
                        w_settle_nxt   = '0;
                        w_bg_valid_nxt = 1'b0;
                        w_consume      = 1'b1;
                    end else if (!run_en) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_settle   <= '0;
            r_pending  <= 1'b0;
            r_bg_valid <= 1'b0;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_tuser    <= 1'b0;
            r_tlast    <= 1'b0;
            r_bg_we    <= 1'b0;
            r_bg_addr  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_settle   <= w_settle_nxt;
            r_bg_valid <= w_bg_valid_nxt;
            // A request on the consuming eof survives and is served at the following eof.
            r_pending  <= (r_pending & ~w_consume) | capture_req;
            r_tvalid   <= s_tvalid;
            if (s_tvalid) begin
                r_tdata <= s_tdata;
            end
            r_tuser <= s_tvalid && (w_idx == '0);
            r_tlast <= w_eol;
            r_bg_we <= s_tvalid && (r_state == ST_CAPTURE);
            // In RUN the read address runs one pixel ahead to absorb synchronous-RAM latency.
            case (r_state)
                ST_CAPTURE: if (s_tvalid) r_bg_addr <= w_idx;
                ST_RUN:     r_bg_addr <= w_idx_nxt;
                default:    r_bg_addr <= '0;
            endcase
            // A beat is lost when it is on the output and downstream is not ready.
            r_overflow <= r_overflow | (r_tvalid & ~m_tready);
        end
    end

    assign m_tvalid = r_tvalid;
    assign m_tdata  = r_tdata;
    assign m_tuser  = r_tuser;
    assign m_tlast  = r_tlast;
    assign bg_we    = r_bg_we;
    assign bg_addr  = r_bg_addr;
    assign state    = r_state;
    assign bg_valid = r_bg_valid;
    assign overflow = r_overflow;

`ifdef FRAME_STATS_EN
    logic [15:0] r_frame_cnt, r_drop_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_eof && (r_state == ST_RUN)) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (r_tvalid && !m_tready && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

endmodule
